// File: rtl/prim_device_pkg.sv
// ============================================================================
// prim_device_pkg : opcodes, field positions and built-in program of prim_device
// Revision: 1.0
// ============================================================================
`default_nettype none

package prim_device_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_EQ   = 5'd10;
    localparam logic [4:0] ALU_NE   = 5'd11;
    localparam logic [4:0] ALU_LT   = 5'd12;
    localparam logic [4:0] ALU_GE   = 5'd13;
    localparam logic [4:0] ALU_LTU  = 5'd14;
    localparam logic [4:0] ALU_GEU  = 5'd15;

    localparam logic [1:0] WS_CONST = 2'd0;
    localparam logic [1:0] WS_SW    = 2'd1;
    localparam logic [1:0] WS_ALU   = 2'd2;
    localparam logic [1:0] WS_RSVD  = 2'd3;

    localparam int BIT_B  = 31;
    localparam int BIT_C  = 30;
    localparam int WS_HI  = 29;
    localparam int WS_LO  = 28;
    localparam int OP_HI  = 27;
    localparam int OP_LO  = 23;
    localparam int RA1_HI = 22;
    localparam int RA1_LO = 18;
    localparam int RA2_HI = 17;
    localparam int RA2_LO = 13;
    localparam int K_HI   = 12;
    localparam int K_LO   = 5;
    localparam int WA_HI  = 4;
    localparam int WA_LO  = 0;

    // Field order: B, C, WS, ALUop, RA1, RA2, const, WA
    localparam logic [31:0] HALT_X2 = {1'b0, 1'b1, WS_CONST, ALU_ADD, 5'd2, 5'd0, 8'h00, 5'd0};

    localparam logic [31:0] PROG_0 = {1'b0, 1'b0, WS_SW,    ALU_ADD, 5'd0, 5'd0, 8'h00, 5'd1};
    localparam logic [31:0] PROG_1 = {1'b0, 1'b0, WS_CONST, ALU_ADD, 5'd0, 5'd0, 8'h00, 5'd2};
    localparam logic [31:0] PROG_2 = {1'b0, 1'b0, WS_CONST, ALU_ADD, 5'd0, 5'd0, 8'h01, 5'd3};
    localparam logic [31:0] PROG_3 = {1'b1, 1'b0, WS_CONST, ALU_EQ,  5'd1, 5'd0, 8'h04, 5'd0};
    localparam logic [31:0] PROG_4 = {1'b0, 1'b0, WS_ALU,   ALU_ADD, 5'd2, 5'd1, 8'h00, 5'd2};
    localparam logic [31:0] PROG_5 = {1'b0, 1'b0, WS_ALU,   ALU_SUB, 5'd1, 5'd3, 8'h00, 5'd1};
    localparam logic [31:0] PROG_6 = {1'b0, 1'b1, WS_CONST, ALU_ADD, 5'd0, 5'd0, 8'hFD, 5'd0};
    localparam logic [31:0] PROG_7 = HALT_X2;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        case (addr)
            32'd0:   return PROG_0;
            32'd1:   return PROG_1;
            32'd2:   return PROG_2;
            32'd3:   return PROG_3;
            32'd4:   return PROG_4;
            32'd5:   return PROG_5;
            32'd6:   return PROG_6;
            32'd7:   return PROG_7;
            default: return HALT_X2;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/prim_alu.sv
// ============================================================================
// prim_alu : combinational ALU, result plus comparison flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module prim_alu
    import prim_device_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  op,
    output logic [31:0] result,
    output logic        flag
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       unused_op_msb;

    assign shamt         = b[4:0];
    assign lt_s          = $signed(a) < $signed(b);
    assign lt_u          = a < b;
    assign unused_op_msb = op[4];

    always_comb begin
        result = '0;
        flag   = 1'b0;
        case ({1'b0, op[3:0]})
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {31'b0, lt_s};
            ALU_SLTU: result = {31'b0, lt_u};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_EQ:   flag   = (a == b);
            ALU_NE:   flag   = (a != b);
            ALU_LT:   flag   = lt_s;
            ALU_GE:   flag   = ~lt_s;
            ALU_LTU:  flag   = lt_u;
            ALU_GEU:  flag   = ~lt_u;
            default:  flag   = 1'b0;
        endcase
        // Comparison ops mirror the flag onto the result
        if (op[3:0] >= 4'd10) begin
            result = {31'b0, flag};
        end
    end

endmodule

`default_nettype wire

// File: rtl/prim_device.sv
// ============================================================================
// prim_device : single-cycle demo processor with ROM, 32x32 regfile and ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module prim_device
    import prim_device_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [2:0]  SW_i,
    output logic [31:0] HEX_o,
    output logic        done_o
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [31:0]     instr;
    logic            br;
    logic            jmp;
    logic [1:0]      ws;
    logic [4:0]      alu_op;
    logic [4:0]      ra1;
    logic [4:0]      ra2;
    logic [7:0]      konst;
    logic [4:0]      wa;
    logic [31:0]     imm;
    logic [31:0]     rd1;
    logic [31:0]     rd2;
    logic [31:0]     alu_res;
    logic            alu_flag;
    logic [31:0]     wd;
    logic            take;
    logic            we;
    logic [31:0]     regs [32];

    assign instr  = rom_word(32'(pc));
    assign br     = instr[BIT_B];
    assign jmp    = instr[BIT_C];
    assign ws     = instr[WS_HI:WS_LO];
    assign alu_op = instr[OP_HI:OP_LO];
    assign ra1    = instr[RA1_HI:RA1_LO];
    assign ra2    = instr[RA2_HI:RA2_LO];
    assign konst  = instr[K_HI:K_LO];
    assign wa     = instr[WA_HI:WA_LO];
    assign imm    = {{24{konst[7]}}, konst};

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

    prim_alu u_alu (
        .a      (rd1),
        .b      (rd2),
        .op     (alu_op),
        .result (alu_res),
        .flag   (alu_flag)
    );

    always_comb begin
        wd = imm;
        case (ws)
            WS_SW:   wd = {29'b0, SW_i};
            WS_ALU:  wd = alu_res;
            default: wd = imm;
        endcase
    end

    assign take    = jmp | (br & alu_flag);
    assign pc_next = pc + (take ? imm[PC_W-1:0] : PC_W'(1));
    assign we      = en_i & ~br & ~jmp & (wa != 5'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (en_i) begin
            pc <= pc_next;
            if (we) begin
                regs[wa] <= wd;
            end
        end
    end

    // HALT is a self-jump; masked while reset is asserted
    assign done_o = jmp & (konst == 8'h00) & rst_i;
    assign HEX_o  = rd1;

endmodule

`default_nettype wire

// File: tb/tb_prim_device.sv
// ============================================================================
// tb_prim_device : randomized/directed self-checking bench for prim_device
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_prim_device;

    logic        clk   = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i  = 1'b0;
    logic [2:0]  sw_i  = 3'd0;
    logic [31:0] hex;
    logic        done;

    logic [31:0] alu_a  = '0;
    logic [31:0] alu_b  = '0;
    logic [4:0]  alu_op = '0;
    logic [31:0] alu_res;
    logic        alu_flag;

    int checks = 0;
    int errors = 0;

    prim_device #(.PC_W(8)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .SW_i   (sw_i),
        .HEX_o  (hex),
        .done_o (done)
    );

    prim_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .flag   (alu_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference ALU built from unsigned arithmetic only
    function automatic void alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic f);
        logic [63:0] ext;
        int          sh;
        bit          lt_s;
        bit          lt_u;
        sh   = int'(b[4:0]);
        lt_s = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        lt_u = a < b;
        ext  = {{32{a[31]}}, a};
        r = '0;
        f = 1'b0;
        case (op[3:0])
            4'd0:  r = a + b;
            4'd1:  r = a + ~b + 32'd1;
            4'd2:  r = a << sh;
            4'd3:  r = 32'(lt_s);
            4'd4:  r = 32'(lt_u);
            4'd5:  r = a ^ b;
            4'd6:  r = a >> sh;
            4'd7:  begin ext = ext >> sh; r = ext[31:0]; end
            4'd8:  r = a | b;
            4'd9:  r = a & b;
            4'd10: f = (a == b);
            4'd11: f = (a != b);
            4'd12: f = lt_s;
            4'd13: f = !lt_s;
            4'd14: f = lt_u;
            default: f = !lt_u;
        endcase
        if (op[3:0] >= 4'd10) r = 32'(f);
    endfunction

    task automatic alu_check(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ef;
        alu_a  = a;
        alu_b  = b;
        alu_op = op;
        #1;
        alu_ref(op, a, b, er, ef);
        check({tag, "_res"}, alu_res, er);
        check({tag, "_flag"}, 32'(alu_flag), 32'(ef));
    endtask

    task automatic reset_dut();
        rst_i = 1'b0;
        en_i  = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        en_i  = 1'b0;
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_hex", hex, 32'd0);
    endtask

    // Program model: sum 1..N lands in x2 after 4N+4 enabled edges.
    task automatic run_prog(input string tag, input int n, input bit rand_en,
                            input int pause_at, input int pause_len, input int exp_cycles);
        int          target;
        int          cnt;
        int          cyc;
        int          paused;
        logic [31:0] exp_sum;
        target  = 4 * n + 4;
        cnt     = 0;
        cyc     = 0;
        paused  = 0;
        exp_sum = 32'(n * (n + 1) / 2);
        sw_i    = n[2:0];
        while (cnt < target && cyc < 500) begin
            if (rand_en) en_i = ($urandom_range(0, 3) != 0);
            else         en_i = !(cnt == pause_at && paused < pause_len);
            @(posedge clk);
            #1;
            cyc++;
            if (en_i) cnt++;
            else      paused++;
            // The switch is only latched by instruction 0
            if (cnt >= 1) sw_i = 3'($urandom);
            #1;
            check({tag, "_done"}, 32'(done), 32'(cnt >= target));
        end
        check({tag, "_reached"}, 32'(cnt), 32'(target));
        check({tag, "_hex"}, hex, exp_sum);
        if (exp_cycles > 0) check({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        en_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_done"}, 32'(done), 32'd1);
            check({tag, "_hold_hex"}, hex, exp_sum);
        end
        en_i = 1'b0;
    endtask

    initial begin
        alu_check("sub_0_1", 5'd1, 32'd0, 32'd1);
        check("sub_0_1_dir", alu_res, 32'hFFFF_FFFF);
        alu_check("sra", 5'd7, 32'h8000_0000, 32'd4);
        check("sra_dir", alu_res, 32'hF800_0000);
        alu_check("ltu", 5'd14, 32'd1, 32'hFFFF_FFFF);
        check("ltu_dir", 32'(alu_flag), 32'd1);
        alu_check("lt", 5'd12, 32'd1, 32'hFFFF_FFFF);
        check("lt_dir", 32'(alu_flag), 32'd0);
        for (int i = 0; i < 64; i++) begin
            alu_check("alu_rand", 5'($urandom), $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
        end

        reset_dut();
        run_prog("sw3", 3, 1'b0, -1, 0, 16);
        reset_dut();
        run_prog("sw0", 0, 1'b0, -1, 0, 4);
        reset_dut();
        run_prog("sw7", 7, 1'b0, -1, 0, 32);

        rst_i = 1'b0;
        #1;
        check("done_masked_by_rst", 32'(done), 32'd0);
        rst_i = 1'b1;

        reset_dut();
        run_prog("sw5_pause", 5, 1'b0, 10, 5, 29);

        reset_dut();
        sw_i = 3'd4;
        en_i = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        en_i  = 1'b0;
        #1;
        check("midrst_hex", hex, 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        run_prog("rerun_sw2", 2, 1'b0, -1, 0, 12);

        for (int k = 0; k < 6; k++) begin
            reset_dut();
            run_prog("rand", int'($urandom_range(0, 7)), 1'b1, -1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
